shift_rows_pipe: RTL and testbench
==================================

# shift_rows_pipe

Elastic, parametrised ShiftRows / InvShiftRows stage for the AES round datapath. It permutes the bytes of LANES independent 128-bit AES states per transaction: forward (encrypt), inverse (decrypt) or bypass, selected per transaction. Results pass through a PIPE_STAGES-deep valid/ready register pipeline with a pass-through tag. It sits between SubBytes and MixColumns and replaces the purely combinational permutation wherever the round needs retiming or backpressure.

## Interface
- LANES, 1: number of parallel 128-bit states; DATA_WIDTH = 128*LANES; lane k occupies bits [128k+127:128k].
- PIPE_STAGES, 2: register stages, legal 1..4.
- TAG_WIDTH, 4: sideband tag carried alongside the data (round index/ID), legal ≥1.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  stage 1 can accept this cycle.
- in_mode  in  2  00 forward, 01 inverse, 10 bypass, 11 illegal.
- in_tag  in  TAG_WIDTH  sideband, unmodified.
- in_data  in  DATA_WIDTH  input states.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts.
- out_tag  out  TAG_WIDTH  tag of the output transaction.
- out_data  out  DATA_WIDTH  permuted states.
- busy  out  1  OR of all stage valid bits.
- err_mode  out  1  sticky: an illegal mode was accepted.

## Operation
- Byte order within each lane: byte 0 = bits [127:120], byte 15 = bits [7:0]. Column-major state, byte i = row i%4, column i/4.
- Forward: out byte i = in byte F[i], F = 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11.
- Inverse: out byte i = in byte I[i], I = 0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3.
- Bypass, and illegal mode 11: out = in. Accepting an illegal mode sets err_mode; only reset clears it.
- All lanes use the same mode. The permutation is applied combinationally before stage 1. Stages 2..PIPE_STAGES are plain registers for data, tag and valid.
- Stage s loads when its valid is 0 or when its contents leave in the same cycle. A stage's contents leave when it is the last stage and out_ready=1, or when stage s+1 loads.
- in_ready equals the stage-1 load condition. It is combinationally dependent on out_ready through the chain; no skid buffer.
- A transaction transfers on in_valid & in_ready and on out_valid & out_ready.
- A stage with valid=0 holds its data; no toggling is required.
- busy = any stage valid.

## Timing
- Reset (async assert, sync release): all stage valids 0, all data and tag registers 0, out_valid=0, out_data=0, out_tag=0, err_mode=0, busy=0. in_ready=1 from the first cycle after reset.
- Latency: a transaction accepted at edge n appears on out_valid/out_data after edge n+PIPE_STAGES-1, i.e. PIPE_STAGES cycles from presentation to capture, with no stalls.
- Throughput: 1 transaction/cycle while out_ready=1.
- Stall: when out_valid=1 and out_ready=0, out_data/out_tag are held stable. Bubbles collapse: upstream stages keep loading until the pipe is full. When all PIPE_STAGES stages are valid and out_ready=0, in_ready=0.
- Simultaneous: when full and out_ready=1, a new input is accepted in the same cycle the output leaves, and occupancy is unchanged.
- Reset mid-operation: all in-flight transactions are discarded immediately and none are emitted after reset.
- Order is strictly preserved; the tag always travels with its data.

## Test plan
- Forward, LANES=1: in_data=d42711aee0bf98f1b8b45de51e415230, mode 00 → out_data=d4bf5d30e0b452aeb84111f11e2798e5 after PIPE_STAGES cycles, out_tag equal to in_tag.
- Inverse round-trip: feed d4bf5d30e0b452aeb84111f11e2798e5 with mode 01 → d42711aee0bf98f1b8b45de51e415230. Repeat on random vectors: inverse(forward(x)) = x.
- Bypass and illegal mode: mode 10 → out=in and err_mode stays 0. Mode 11 → out=in, err_mode=1 from the accept edge onward, and it stays set until rst_n is asserted.
- Backpressure, PIPE_STAGES=3: stream 10 tagged transactions and hold out_ready=0 for 5 cycles → exactly 3 accepted, then in_ready=0 and out_data stable. On release, all 10 emerge in order with no loss or duplication.
- LANES=4 with each lane a different FIPS vector and mode 00 → each lane is permuted independently in its own bit slice.
- Assert rst_n low with 2 transactions in flight → out_valid=0 and busy=0 immediately. After release, no stale outputs appear, and err_mode and all data outputs are 0.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: an elastic ShiftRows / InvShiftRows / bypass stage for the AES datapath.
// The byte permutation is applied combinationally at the input. The result then moves through
// a PIPE_STAGES-deep valid/ready register chain, and the sideband tag travels with its data.
module shift_rows_pipe #(
  parameter int LANES       = 1,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_mode,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  input  logic [128*LANES-1:0]     in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic [128*LANES-1:0]     out_data,
  output logic                     busy,
  output logic                     err_mode
);

  localparam int DATA_WIDTH = 128 * LANES;
  localparam int LAST       = PIPE_STAGES - 1;

  // Source byte index for each output byte. Nibble i (MSB first) holds the source of out byte i.
  localparam logic [63:0] FWD_TAB = 64'h05AF_49E3_8D27_C16B;
  localparam logic [63:0] INV_TAB = 64'h0DA7_41EB_852F_C963;

  function automatic int tab_at(input logic [63:0] tab, input int idx);
    return int'(tab[63-4*idx -: 4]);
  endfunction

  logic [DATA_WIDTH-1:0] w_fwd;
  logic [DATA_WIDTH-1:0] w_inv;
  logic [DATA_WIDTH-1:0] w_perm;
  logic [PIPE_STAGES-1:0] w_load;
  logic                   w_accept;

  logic [PIPE_STAGES-1:0] r_valid;
  logic [DATA_WIDTH-1:0]  r_data [PIPE_STAGES];
  logic [TAG_WIDTH-1:0]   r_tag  [PIPE_STAGES];
  logic                   r_err;

  // Each lane is permuted on its own. Byte 0 is the most significant byte of the lane.
  genvar gi, gj;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      for (gj = 0; gj < 16; gj++) begin : g_byte
        localparam int SRC_F = tab_at(FWD_TAB, gj);
        localparam int SRC_I = tab_at(INV_TAB, gj);
        assign w_fwd[128*gi+127-8*gj -: 8] = in_data[128*gi+127-8*SRC_F -: 8];
        assign w_inv[128*gi+127-8*gj -: 8] = in_data[128*gi+127-8*SRC_I -: 8];
      end
    end
  endgenerate

  // Select the permutation. Bypass and the illegal mode both pass the data through unchanged.
  always_comb begin
    w_perm = in_data;
    case (in_mode)
      2'b00:   w_perm = w_fwd;
      2'b01:   w_perm = w_inv;
      default: w_perm = in_data;
    endcase
  end

  // Load conditions ripple back from the output: a stage loads when it is empty or when it drains this cycle.
  always_comb begin
    w_load       = '0;
    w_load[LAST] = !r_valid[LAST] || out_ready;
    for (int s = LAST - 1; s >= 0; s--) begin
      w_load[s] = !r_valid[s] || w_load[s+1];
    end
  end

  assign w_accept = in_valid && w_load[0];

  // Pipeline registers. The data and tag of a stage change only when valid contents arrive,
  // so bubbles never toggle the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_data[s] <= '0;
        r_tag[s]  <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= w_perm;
          r_tag[0]  <= in_tag;
        end
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        if (w_load[s]) begin
          r_valid[s] <= r_valid[s-1];
          if (r_valid[s-1]) begin
            r_data[s] <= r_data[s-1];
            r_tag[s]  <= r_tag[s-1];
          end
        end
      end
    end
  end

  // Sticky flag: once a transaction with mode 11 is accepted, it stays set until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept && (in_mode == 2'b11)) begin
      r_err <= 1'b1;
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_valid[LAST];
  assign out_data  = r_data[LAST];
  assign out_tag   = r_tag[LAST];
  assign busy      = |r_valid;
  assign err_mode  = r_err;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: a table of known ShiftRows vectors, a randomized stream checked against a
// row/column rotation model, and hand sequences for backpressure and reset with data in flight.
module tb_shift_rows_pipe;

  localparam int LANES = 4;
  localparam int PS    = 3;
  localparam int TW    = 4;
  localparam int DW    = 128 * LANES;

  localparam logic [127:0] VA  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] VFA = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] VP  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VFP = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] VIP = 128'h000d0a0704010e0b0805020f0c090603;
  localparam logic [127:0] VC  = {16{8'h5a}};
  localparam logic [127:0] VZ  = 128'h0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_tag;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          err_mode;

  always #5 clk = ~clk;

  shift_rows_pipe #(.LANES(LANES), .PIPE_STAGES(PS), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_tag(in_tag), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
    .busy(busy), .err_mode(err_mode)
  );

  typedef struct {
    logic [1:0]    mode;
    logic [TW-1:0] tag;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
  } vec_t;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } sb_t;

  vec_t          tbl [6];
  sb_t           sbq [$];
  int            total = 0;
  int            bad   = 0;
  int            out_count = 0;
  logic          in_fire;
  logic          out_fire;
  logic [DW-1:0] last_out;

  // Reference: view the lane as a 4x4 column-major byte matrix and rotate row r left (forward)
  // or right (inverse) by r positions.
  function automatic logic [127:0] ref_lane(input logic [127:0] x, input logic [1:0] m);
    logic [7:0]   st [4][4];
    logic [127:0] y;
    int           src;
    for (int b = 0; b < 16; b++) st[b % 4][b / 4] = x[127-8*b -: 8];
    y = x;
    if (m == 2'b00 || m == 2'b01) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          src = (m == 2'b00) ? (c + r) % 4 : (c - r + 4) % 4;
          y[127-8*(4*c+r) -: 8] = st[r][src];
        end
      end
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] ref_model(input logic [DW-1:0] d, input logic [1:0] m);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[128*k +: 128] = ref_lane(d[128*k +: 128], m);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a falling edge with the inputs already driven. It samples the handshakes, updates the
  // scoreboard for whatever transfers on the coming rising edge, then returns at the next falling edge.
  task automatic tick();
    sb_t e;
    #1;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (in_fire) begin
      e.tag  = in_tag;
      e.data = ref_model(in_data, in_mode);
      sbq.push_back(e);
    end
    if (out_fire) begin
      out_count++;
      last_out = out_data;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output actual_tag=%h actual=%h required=none", out_tag, out_data);
      end else begin
        e = sbq.pop_front();
        chk("sb_data", out_data, e.data);
        chk("sb_tag", DW'(out_tag), DW'(e.tag));
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sbq.size() > 0 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_left", DW'(sbq.size()), DW'(0));
  endtask

  task automatic send_one(input logic [1:0] m, input logic [TW-1:0] t, input logic [DW-1:0] d);
    in_valid  = 1'b1;
    in_mode   = m;
    in_tag    = t;
    in_data   = d;
    out_ready = 1'b1;
    tick();
    chk("send_accept", DW'(in_fire), DW'(1));
    in_valid = 1'b0;
  endtask

  initial begin
    int            lat;
    int            acc;
    int            n;
    int            out_before;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] snap;
    logic [DW-1:0] bp_data [10];

    tbl[0] = '{mode: 2'b00, tag: 4'h1, din: {VZ, VC, VP, VA},    dout: {VZ, VC, VFP, VFA}};
    tbl[1] = '{mode: 2'b01, tag: 4'h2, din: {VC, VZ, VFP, VFA},  dout: {VC, VZ, VP, VA}};
    tbl[2] = '{mode: 2'b01, tag: 4'h3, din: {VP, VP, VP, VP},    dout: {VIP, VIP, VIP, VIP}};
    tbl[3] = '{mode: 2'b00, tag: 4'h4, din: {VIP, VA, VIP, VA},  dout: {VP, VFA, VP, VFA}};
    tbl[4] = '{mode: 2'b10, tag: 4'h5, din: {VA, VP, VC, VFA},   dout: {VA, VP, VC, VFA}};
    tbl[5] = '{mode: 2'b11, tag: 4'hE, din: {VFP, VIP, VA, VC},  dout: {VFP, VIP, VA, VC}};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_tag    = '0;
    in_data   = '0;
    out_ready = 1'b0;
    last_out  = '0;
    in_fire   = 1'b0;
    out_fire  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", DW'(in_ready), DW'(1));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_tag", DW'(out_tag), DW'(0));
    chk("rst_err_mode", DW'(err_mode), DW'(0));

    // Known vectors, one at a time, checking latency, data and the sticky error flag.
    for (int i = 0; i < 6; i++) begin
      send_one(tbl[i].mode, tbl[i].tag, tbl[i].din);
      chk("tbl_err_mode", DW'(err_mode), DW'(tbl[i].mode == 2'b11));
      lat = 0;
      do begin
        tick();
        lat++;
      end while (!out_fire && lat < 10);
      chk("tbl_latency", DW'(lat), DW'(PS));
      chk("tbl_data", last_out, tbl[i].dout);
    end

    // Round trip through the DUT: inverse(forward(x)) == x.
    for (int i = 0; i < 4; i++) begin
      x = rand_wide();
      send_one(2'b00, TW'(i), x);
      drain();
      y = last_out;
      send_one(2'b01, TW'(i), y);
      drain();
      chk("roundtrip", last_out, x);
    end

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 4) != 0;
      in_mode   = 2'($urandom % 4);
      in_tag    = TW'($urandom);
      in_data   = rand_wide();
      out_ready = ($urandom % 3) != 0;
      tick();
    end
    drain();
    chk("err_mode_sticky", DW'(err_mode), DW'(1));

    // Backpressure: the pipe holds exactly PS transactions, then blocks with a stable output.
    for (int i = 0; i < 10; i++) bp_data[i] = rand_wide();
    out_before = out_count;
    acc        = 0;
    snap       = '0;
    out_ready  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_tag   = TW'(acc);
      in_data  = bp_data[acc];
      in_mode  = 2'(acc % 3);
      tick();
      if (in_fire) acc++;
      if (c == 2) snap = out_data;
    end
    chk("bp_accepted", DW'(acc), DW'(PS));
    #1;
    chk("bp_in_ready", DW'(in_ready), DW'(0));
    chk("bp_out_valid", DW'(out_valid), DW'(1));
    chk("bp_out_stable", out_data, snap);
    @(negedge clk);
    out_ready = 1'b1;
    n = 0;
    while (acc < 10 && n < 40) begin
      in_valid = 1'b1;
      in_tag   = TW'(acc);
      in_data  = bp_data[acc];
      in_mode  = 2'(acc % 3);
      tick();
      if (in_fire) acc++;
      n++;
    end
    chk("bp_all_accepted", DW'(acc), DW'(10));
    drain();
    chk("bp_out_count", DW'(out_count - out_before), DW'(10));

    // Reset with transactions in flight: outputs clear at once and nothing stale emerges afterwards.
    out_ready = 1'b0;
    send_one(2'b11, 4'hA, rand_wide());
    out_ready = 1'b0;
    send_one(2'b00, 4'hB, rand_wide());
    out_ready = 1'b0;
    tick();
    chk("pre_rst_out_valid", DW'(out_valid), DW'(1));
    chk("pre_rst_err_mode", DW'(err_mode), DW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", DW'(out_valid), DW'(0));
    chk("async_rst_busy", DW'(busy), DW'(0));
    sbq.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    out_before = out_count;
    repeat (6) tick();
    chk("post_rst_no_output", DW'(out_count - out_before), DW'(0));
    chk("post_rst_err_mode", DW'(err_mode), DW'(0));
    chk("post_rst_out_data", out_data, '0);
    chk("post_rst_out_tag", DW'(out_tag), DW'(0));
    chk("post_rst_in_ready", DW'(in_ready), DW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
